// File: rtl/conv_seq_ctrl.sv
// Sequencer for the bit-serial convolution engine: latches one window, feeds it
// LSB-first one beat per handshake and assembles the engine's 2-bit result slices.
module conv_seq_ctrl #(
  parameter int KERNEL_SIZE = 25,
  parameter int DATA_WIDTH  = 8,
  parameter int N_BEATS     = 13,
  parameter int OUT_BEATS   = 8,
  parameter int RES_W       = 2*OUT_BEATS
) (
  input  logic                              i_clk,
  input  logic                              i_arstn,
  input  logic                              i_win_valid,
  output logic                              o_win_ready,
  input  logic [KERNEL_SIZE*DATA_WIDTH-1:0] i_x_flat,
  input  logic [KERNEL_SIZE*DATA_WIDTH-1:0] i_k_flat,
  output logic                              o_eng_valid,
  input  logic                              i_eng_ready,
  output logic [KERNEL_SIZE-1:0]            o_eng_bit_x,
  output logic [KERNEL_SIZE-1:0]            o_eng_bit_k,
  input  logic                              i_eng_valid,
  input  logic [1:0]                        i_eng_conv,
  output logic                              o_eng_ack,
  output logic                              o_res_valid,
  input  logic                              i_res_ready,
  output logic [RES_W-1:0]                  o_res_data,
  output logic                              o_res_err,
  output logic                              o_busy,
  output logic [31:0]                       o_win_count
);

  localparam int FLAT_W  = KERNEL_SIZE*DATA_WIDTH;
  localparam int BEAT_W  = $clog2(N_BEATS);
  localparam int SLICE_W = $clog2(OUT_BEATS+1);
  localparam logic [BEAT_W-1:0]  LAST_BEAT   = BEAT_W'(N_BEATS-1);
  localparam logic [SLICE_W-1:0] SLICES_FULL = SLICE_W'(OUT_BEATS);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_LO, S_WAIT_RES, S_ACK, S_WAIT_IDLE, S_NEXT, S_DONE
  } state_t;

  state_t              state;
  logic [FLAT_W-1:0]   x_shadow;
  logic [FLAT_W-1:0]   k_shadow;
  logic [BEAT_W-1:0]   beat;
  logic [SLICE_W-1:0]  slices;

  // Shifting a lane past its MSB yields zero, which gives the padding beats for free.
  function automatic logic [KERNEL_SIZE-1:0] beat_bits(input logic [FLAT_W-1:0] flat,
                                                       input logic [BEAT_W-1:0] b);
    logic [KERNEL_SIZE-1:0] bits;
    logic [DATA_WIDTH-1:0]  lane;
    bits = '0;
    for (int i = 0; i < KERNEL_SIZE; i++) begin
      lane    = flat[i*DATA_WIDTH +: DATA_WIDTH] >> b;
      bits[i] = lane[0];
    end
    return bits;
  endfunction

  always_ff @(posedge i_clk) begin
    if (!i_arstn) begin
      state       <= S_IDLE;
      x_shadow    <= '0;
      k_shadow    <= '0;
      beat        <= '0;
      slices      <= '0;
      o_res_data  <= '0;
      o_res_err   <= 1'b0;
      o_res_valid <= 1'b0;
      o_eng_valid <= 1'b0;
      o_eng_ack   <= 1'b1;
      o_eng_bit_x <= '0;
      o_eng_bit_k <= '0;
      o_win_ready <= 1'b1;
      o_busy      <= 1'b0;
      o_win_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_win_valid) begin
            x_shadow    <= i_x_flat;
            k_shadow    <= i_k_flat;
            beat        <= '0;
            slices      <= '0;
            o_res_err   <= 1'b0;
            o_res_data  <= '0;
            o_eng_bit_x <= beat_bits(i_x_flat, '0);
            o_eng_bit_k <= beat_bits(i_k_flat, '0);
            o_eng_valid <= 1'b1;
            o_win_ready <= 1'b0;
            o_busy      <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (i_eng_ready) begin
            o_eng_valid <= 1'b0;
            state       <= S_WAIT_LO;
          end
        end
        S_WAIT_LO: begin
          if (!i_eng_ready) state <= S_WAIT_RES;
        end
        S_WAIT_RES: begin
          if (i_eng_valid) begin
            // Slices beyond the result width are dropped but flagged.
            if (slices != SLICES_FULL) begin
              for (int s = 0; s < OUT_BEATS; s++)
                if (slices == SLICE_W'(s)) o_res_data[2*s +: 2] <= i_eng_conv;
              slices <= slices + 1'b1;
            end else begin
              o_res_err <= 1'b1;
            end
            o_eng_ack <= 1'b0;
            state     <= S_ACK;
          end else if (i_eng_ready) begin
            state <= S_NEXT;
          end
        end
        S_ACK: begin
          o_eng_ack <= 1'b1;
          state     <= S_WAIT_IDLE;
        end
        S_WAIT_IDLE: begin
          if (i_eng_ready) state <= S_NEXT;
        end
        S_NEXT: begin
          if (beat == LAST_BEAT) begin
            if (slices != SLICES_FULL) o_res_err <= 1'b1;
            o_res_valid <= 1'b1;
            state       <= S_DONE;
          end else begin
            beat        <= beat + 1'b1;
            o_eng_bit_x <= beat_bits(x_shadow, beat + 1'b1);
            o_eng_bit_k <= beat_bits(k_shadow, beat + 1'b1);
            o_eng_valid <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_DONE: begin
          if (i_res_ready) begin
            o_res_valid <= 1'b0;
            o_win_count <= o_win_count + 32'd1;
            o_win_ready <= 1'b1;
            o_busy      <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/conv_seq_ctrl.md
Name: conv_seq_ctrl

Overview:
Sequencer for the bit-serial 25-lane convolution engine. It accepts one full convolution window (X and K vectors, parallel) over a valid/ready handshake, then serializes it LSB-first as one bit per lane per beat into the engine. It captures the engine's 2-bit output slices and assembles them into one result word, which it presents on a valid/ready result port. It sits between the window buffer and the engine and owns all engine handshaking.

Parameters:
KERNEL_SIZE, 25, lanes per window (one serial multiplier per lane)
DATA_WIDTH, 8, bits per X/K element
N_BEATS, 13, input beats issued to the engine per window; beats at index DATA_WIDTH and above drive zero bits
OUT_BEATS, 8, output slices expected per window
RES_W, 2*OUT_BEATS, result word width

Ports:
i_clk  in  1  clock
i_arstn  in  1  reset, synchronous, active-low
i_win_valid  in  1  window offered
o_win_ready  out  1  controller can accept a window
i_x_flat  in  KERNEL_SIZE*DATA_WIDTH  X elements; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
i_k_flat  in  KERNEL_SIZE*DATA_WIDTH  K elements, same packing
o_eng_valid  out  1  to engine i_valid
i_eng_ready  in  1  from engine o_ready (engine idle)
o_eng_bit_x  out  KERNEL_SIZE  current beat X bits
o_eng_bit_k  out  KERNEL_SIZE  current beat K bits
i_eng_valid  in  1  from engine o_valid
i_eng_conv  in  2  engine output slice
o_eng_ack  out  1  to engine i_ready
o_res_valid  out  1  result available
i_res_ready  in  1  result consumer ready
o_res_data  out  RES_W  assembled result
o_res_err  out  1  slice count mismatch for this result
o_busy  out  1  high in any state other than IDLE
o_win_count  out  32  windows completed since reset

Behaviour:
- Reset (i_arstn low at a rising edge): state IDLE.
  - All counters, X/K shadow registers and o_res_data cleared.
  - o_eng_valid=0, o_eng_ack=1, o_res_valid=0, o_res_err=0, o_win_count=0.
  - o_win_ready=1 from the first cycle after reset.
  - Reset mid-window abandons the window with no output.
- o_win_ready=1 only in IDLE. A window is accepted when i_win_valid & o_win_ready at an edge.
  - On acceptance: latch i_x_flat and i_k_flat, beat=0, slices=0, err=0, go ISSUE.
- o_eng_bit_x[i] = X_lane_i[beat] if beat<DATA_WIDTH, else 0. o_eng_bit_k is formed the same way. Both are registered and stable throughout ISSUE.
- ISSUE: o_eng_valid=1.
  - When i_eng_ready is sampled 1 at an edge, the beat is issued: go WAIT_LO.
- WAIT_LO: o_eng_valid=0. Wait for i_eng_ready=0 (engine has left idle), then go WAIT_RES.
- WAIT_RES:
  - If i_eng_valid=1 and slices<OUT_BEATS: store i_eng_conv in o_res_data[2*slices+1:2*slices], slices+1, go ACK.
  - If i_eng_valid=1 and slices=OUT_BEATS: discard the slice, set err, go ACK.
  - Else if i_eng_ready=1 (beat produced no slice): go NEXT.
- ACK: o_eng_ack=0 for exactly one cycle, then o_eng_ack=1. Go WAIT_IDLE.
- WAIT_IDLE: wait for i_eng_ready=1, then go NEXT.
- NEXT (1 cycle):
  - If beat=N_BEATS-1: go DONE; err |= (slices != OUT_BEATS) after the final update.
  - Else: beat+1, go ISSUE.
- DONE: o_res_valid=1; o_res_data and o_res_err held stable.
  - On i_res_valid&i_res_ready handshake: o_win_count+1 (wraps at 2^32), go IDLE.
  - o_win_ready rises the cycle after the handshake. There is no combinational ready-to-ready path.
- o_eng_ack=1 in every state except ACK.
- An i_eng_valid outside WAIT_RES is ignored.
- At most one window is in flight; there is no buffering.

Test Plan:
- Reset held 3 cycles, then released → o_win_ready=1, o_res_valid=0, o_eng_valid=0, o_eng_ack=1, o_win_count=0.
- Window with X lane0=8'hA5, K=all ones, engine model → beat b drives o_eng_bit_x[0]=bit b of 0xA5 (1,0,1,0,0,1,0,1), then 0 for beats 8..12; exactly 13 o_eng_valid acceptances.
- Engine model returns slices k%4 on output beats 5..12 → o_res_data=16'hE4E4, o_res_err=0, o_win_count=1 after handshake.
- i_res_ready held low 10 cycles in DONE → o_res_valid and o_res_data stable throughout; o_win_ready=0; no new window accepted.
- Engine model emits 9 slices (extra on beat 4) → ninth slice discarded, o_res_err=1; model emits 7 slices → o_res_err=1.
- Reset asserted during beat 6 → next cycle IDLE, all outputs at reset values; following window completes normally with o_win_count=1.
